tone_sequencer: RTL



---
 rtl/tone_seq_pkg.sv | 84 ++++++++
 rtl/tone_seq_timer.sv | 37 +++
 rtl/tone_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg
// Shared definitions for the tone sequencer:
//   - event encodings (0 none, 1 unlock, 2 correct, 3 incorrect); a larger
//     code means a higher priority
//   - sequencer state enum
//   - note half-periods (clk cycles at 50 MHz) and the melody lookup
//   - request helpers: priority pick and event-to-request-bit mapping
package tone_seq_pkg;

  localparam logic [1:0] EVT_NONE      = 2'd0;
  localparam logic [1:0] EVT_UNLOCK    = 2'd1;
  localparam logic [1:0] EVT_CORRECT   = 2'd2;
  localparam logic [1:0] EVT_INCORRECT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [16:0] HP_C4 = 17'd95556;
  localparam logic [16:0] HP_E4 = 17'd75843;
  localparam logic [16:0] HP_G4 = 17'd63776;
  localparam logic [16:0] HP_C5 = 17'd47778;
  localparam logic [16:0] HP_E5 = 17'd37922;
  localparam logic [16:0] HP_G5 = 17'd31888;
  localparam logic [16:0] HP_C6 = 17'd23889;

  // Half-period of note idx (0..2) of the melody for evt; 0 for anything else.
  function automatic logic [16:0] melody_hp(input logic [1:0] evt, input logic [1:0] idx);
    logic [16:0] hp;
    hp = '0;
    case (evt)
      EVT_UNLOCK: begin
        case (idx)
          2'd0:    hp = HP_C5;
          2'd1:    hp = HP_E5;
          2'd2:    hp = HP_G5;
          default: hp = '0;
        endcase
      end
      EVT_CORRECT: begin
        case (idx)
          2'd0:    hp = HP_G5;
          2'd1:    hp = HP_G5;
          2'd2:    hp = HP_C6;
          default: hp = '0;
        endcase
      end
      EVT_INCORRECT: begin
        case (idx)
          2'd0:    hp = HP_G4;
          2'd1:    hp = HP_E4;
          2'd2:    hp = HP_C4;
          default: hp = '0;
        endcase
      end
      default: hp = '0;
    endcase
    return hp;
  endfunction

  // Request vector bit n corresponds to event code n.
  function automatic logic [1:0] pick_evt(input logic [3:1] req);
    logic [1:0] evt;
    if (req[3])      evt = EVT_INCORRECT;
    else if (req[2]) evt = EVT_CORRECT;
    else if (req[1]) evt = EVT_UNLOCK;
    else             evt = EVT_NONE;
    return evt;
  endfunction

  function automatic logic [3:1] evt_bit(input logic [1:0] evt);
    logic [3:1] b;
    case (evt)
      EVT_UNLOCK:    b = 3'b001;
      EVT_CORRECT:   b = 3'b010;
      EVT_INCORRECT: b = 3'b100;
      default:       b = 3'b000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tone_seq_timer.sv
// tone_seq_timer
// Loadable down-counter shared by the NOTE and GAP phases. Loading value
// N-1 makes tc assert during the N-th cycle after the load edge.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   load        load load_val on the next edge (takes precedence over counting)
//   load_val    reload value
//   tc          terminal count: counter is at zero
module tone_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer
// Arbitrates one-cycle event requests (priority incorrect > correct > unlock)
// and plays each granted event as a three-note melody by driving the tone
// generator's half-period and enable. Requests arriving while busy are queued
// in a pending bit per event (repeats merge). All outputs are registered.
// Optional build macro TONE_SEQ_PREEMPT_EN: a request of strictly higher
// priority than the playing event aborts it and starts immediately.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   evt_unlock/_correct/_incorrect  one-cycle request pulses
//   tone_en            high while a note sounds
//   tone_half_period   half-period in clk cycles of the current note
//   active_evt         playing event (0 none, 1 unlock, 2 correct, 3 incorrect)
//   note_idx           current note index 0..2
//   busy               high in NOTE or GAP
//   done               one-cycle pulse when a melody completes
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int NOTE_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int HP_W        = 17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            evt_unlock,
  input  logic            evt_correct,
  input  logic            evt_incorrect,
  output logic            tone_en,
  output logic [HP_W-1:0] tone_half_period,
  output logic [1:0]      active_evt,
  output logic [1:0]      note_idx,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t          state_q, state_d;
  logic [3:1]      pending_q, pending_d;
  logic            tone_en_q, tone_en_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [1:0]      active_q, active_d;
  logic [1:0]      idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;

  logic [3:1] req_in;
  logic       start_en;
  logic [1:0] start_evt;
  logic       next_note;
  logic       melody_end;

  assign req_in = {evt_incorrect, evt_correct, evt_unlock};

  tone_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | req_in;
    tone_en_d  = tone_en_q;
    hp_d       = hp_q;
    active_d   = active_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = NOTE_LOAD;
    start_en   = 1'b0;
    start_evt  = EVT_NONE;
    next_note  = 1'b0;
    melody_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending_d != '0) begin
          start_en  = 1'b1;
          start_evt = pick_evt(pending_d);
        end
      end
      ST_NOTE: begin
        if (tmr_tc) begin
          if (idx_q != 2'd2) begin
            if (GAP_CYCLES == 0) begin
              next_note = 1'b1;
            end else begin
              state_d   = ST_GAP;
              tone_en_d = 1'b0;
              tmr_load  = 1'b1;
              tmr_val   = GAP_LOAD;
            end
          end else begin
            melody_end = 1'b1;
            done_d     = 1'b1;
            // Back-to-back: the highest queued event starts on the same edge.
            if (pending_d != '0) begin
              start_en  = 1'b1;
              start_evt = pick_evt(pending_d);
            end else begin
              state_d   = ST_IDLE;
              tone_en_d = 1'b0;
              hp_d      = '0;
              active_d  = EVT_NONE;
              idx_d     = 2'd0;
            end
          end
        end
      end
      ST_GAP: begin
        if (tmr_tc) next_note = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TONE_SEQ_PREEMPT_EN
    // A completing melody is left to the normal hand-off so a queued
    // higher-priority event is not skipped by a lower incoming one.
    if ((state_q != ST_IDLE) && !melody_end && (pick_evt(req_in) > active_q)) begin
      next_note = 1'b0;
      start_en  = 1'b1;
      start_evt = pick_evt(req_in);
    end
`endif

    if (next_note) begin
      state_d   = ST_NOTE;
      idx_d     = idx_q + 2'd1;
      hp_d      = HP_W'(melody_hp(active_q, idx_d));
      tone_en_d = 1'b1;
      tmr_load  = 1'b1;
      tmr_val   = NOTE_LOAD;
    end

    if (start_en) begin
      state_d   = ST_NOTE;
      active_d  = start_evt;
      idx_d     = 2'd0;
      hp_d      = HP_W'(melody_hp(start_evt, 2'd0));
      tone_en_d = 1'b1;
      tmr_load  = 1'b1;
      tmr_val   = NOTE_LOAD;
      pending_d = pending_d & ~evt_bit(start_evt);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      tone_en_q <= 1'b0;
      hp_q      <= '0;
      active_q  <= EVT_NONE;
      idx_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      tone_en_q <= tone_en_d;
      hp_q      <= hp_d;
      active_q  <= active_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tone_en          = tone_en_q;
  assign tone_half_period = hp_q;
  assign active_evt       = active_q;
  assign note_idx         = idx_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
